data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory controller: one request at a time through IDLE -> ACCESS -> RESP,
// with byte-lane stores, sign/zero-extended loads and alignment/range error reporting.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  ram_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [2:0]    funct3_c;
    logic          is_load_c;
    logic [AW-1:0] idx_c;
    logic          req_err_c;
    logic [3:0]    be_c;
    logic [31:0]   wr_word_c;
    logic          wr_en_c;

    assign funct3_c  = sel_q[3:1];
    assign is_load_c = sel_q[0];
    assign idx_c     = addr_q[AW+1:2];

    // Legality of the captured request: opcode, alignment and word range.
    always_comb begin
        req_err_c = 1'b0;
        case (funct3_c)
            3'b000:  req_err_c = 1'b0;
            3'b001:  req_err_c = addr_q[0];
            3'b010:  req_err_c = (addr_q[1:0] != 2'b00);
            3'b100:  req_err_c = !is_load_c;
            3'b101:  req_err_c = !is_load_c || addr_q[0];
            default: req_err_c = 1'b1;
        endcase
        if (addr_q[31:AW+2] != '0) begin
            req_err_c = 1'b1;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_c      = 4'b1111;
        wr_word_c = wdata_q;
        case (funct3_c[1:0])
            2'b00: begin
                be_c      = 4'b0001 << addr_q[1:0];
                wr_word_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_c      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c      = 4'b1111;
                wr_word_c = wdata_q;
            end
        endcase
    end

    assign wr_en_c = (state_q == ACCESS) && !is_load_c && !req_err_c;

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    sel_d   = ram_sel;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                word_d  = mem[idx_c];
                err_d   = req_err_c;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rdata_d     = (err_q || !sel_q[0]) ? '0 : fmt_load(sel_q[3:1], addr_q[1:0], word_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            err_q       <= err_d;
        end
    end

    // Storage is deliberately unreset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem[idx_c][8*i +: 8] <= wr_word_c[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference model with a per-cycle compare
// process, directed literal checks and randomized request traffic.
module tb_data_mem_ctrl;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  ram_sel = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ram_sel   (ram_sel),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
        logic        st;
        logic [31:0] a;
        int          size;
        logic [31:0] wd;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb [4*DEPTH];
    logic [31:0] init_w [DEPTH];
    int          cyc = 0;
    int          ready_at = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: memory as a flat byte array, accesses as size/offset arithmetic.
    function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [2:0]  f3;
        logic        ld;
        logic        legal;
        int          size;
        logic [31:0] v;
        f3    = s[3:1];
        ld    = s[0];
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size  = 1 << f3[1:0];
        e.due  = 0;
        e.a    = a;
        e.wd   = wd;
        e.size = size;
        e.err  = !legal || ((a % 32'(size)) != 0) || ((a >> 2) >= 32'(DEPTH));
        e.st   = !e.err && !ld;
        e.rd   = '0;
        if (!e.err && ld) begin
            v = '0;
            for (int i = 0; i < size; i++) begin
                v = v | (32'(mb[int'(a) + i]) << (8 * i));
            end
            if (!f3[2] && size < 4 && v[8*size-1]) begin
                v = v | ~((32'd1 << (8 * size)) - 32'd1);
            end
            e.rd = v;
        end
        return e;
    endfunction

    // One clock of stimulus; the model decides acceptance from its own ready prediction.
    task automatic step(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] wd);
        logic acc;
        exp_t e;
        req_valid = v;
        ram_sel   = s;
        addr      = a;
        wdata     = wd;
        acc = v && rst_n && (cyc >= ready_at);
        @(posedge clk);
        cyc++;
        if (acc) begin
            e     = model(s, a, wd);
            e.due = cyc + 2;
            q.push_back(e);
            ready_at = cyc + 2;
        end
        #1;
    endtask

    task automatic lit(input string name, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
        step(1'b1, s, a, wd);
        step(1'b1, 4'($urandom), $urandom, $urandom);
        step(1'b1, 4'($urandom), $urandom, $urandom);
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rdata"}, rdata, erd);
        chk({name, " rsp_err"}, 32'(rsp_err), 32'(eerr));
    endtask

    always @(negedge clk) begin : compare
        logic        ev;
        logic        ee;
        logic [31:0] erd;
        exp_t        e;
        ev  = 1'b0;
        ee  = 1'b0;
        erd = '0;
        if (q.size() != 0 && q[0].due == cyc) begin
            e   = q.pop_front();
            ev  = 1'b1;
            erd = e.rd;
            ee  = e.err;
            if (e.st) begin
                for (int i = 0; i < e.size; i++) begin
                    mb[int'(e.a) + i] = e.wd[8*i +: 8];
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(cyc >= ready_at));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rdata", rdata, erd);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
    end

    initial begin : stim
        int          cnt;
        logic [31:0] ra;
        rst_n = 1'b0;
        step(1'b1, 4'b0101, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < int'(DEPTH); w++) begin
            init_w[w] = $urandom;
            step(1'b1, 4'b0100, 32'(4 * w), init_w[w]);
            step(1'b0, 4'b0000, 32'h0, 32'h0);
            step(1'b0, 4'b0000, 32'h0, 32'h0);
        end

        // Aborted store: reset lands while the store sits in ACCESS.
        step(1'b1, 4'b0100, 32'h20, 32'h1234_5678);
        rst_n = 1'b0;
        q.delete();
        ready_at = cyc;
        step(1'b1, 4'b0101, 32'h20, 32'h0);
        step(1'b1, 4'b0101, 32'h20, 32'h0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        chk("abort req_ready", 32'(req_ready), 32'd1);
        lit("abort LW", 4'b0101, 32'h20, 32'h0, init_w[8], 1'b0);

        lit("SW 0x10", 4'b0100, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        lit("LW 0x10", 4'b0101, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        lit("SB 0x11", 4'b0000, 32'h11, 32'h0000_0080, 32'h0, 1'b0);
        lit("LB 0x11", 4'b0001, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
        lit("LBU 0x11", 4'b1001, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
        lit("LW 0x10 after SB", 4'b0101, 32'h10, 32'h0, 32'hDEAD_80EF, 1'b0);
        lit("SH 0x13", 4'b0010, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1);
        lit("LW 0x12", 4'b0101, 32'h12, 32'h0, 32'h0, 1'b1);
        lit("LW 0x10 unchanged", 4'b0101, 32'h10, 32'h0, 32'hDEAD_80EF, 1'b0);
        lit("LH 0x12", 4'b0011, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
        lit("load f3=011", 4'b0111, 32'h10, 32'h0, 32'h0, 1'b1);
        lit("LW out of range", 4'b0101, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);

        // Continuous req_valid: ready should run 0,0,1 after each acceptance.
        chk("b2b start ready", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 4'b0101, 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0);
            chk("b2b req_ready", 32'(req_ready), 32'((k % 3) == 0));
            if (rsp_valid) cnt++;
        end
        chk("b2b rsp count", 32'(cnt), 32'd3);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
                default: ra = 32'($urandom_range(0, 4 * DEPTH - 1));
            endcase
            step(($urandom_range(0, 3) != 0), 4'($urandom), ra, $urandom);
        end
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
